// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and pipe_ctrl: hazard inputs,
// stall/flush/forward controls, FSM state and performance counters.
interface pipe_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rs, id_rt;
  logic             id_uses_rs, id_uses_rt;
  logic [REG_W-1:0] ex_rs, ex_rt, ex_dst;
  logic             ex_memread;
  logic [REG_W-1:0] exmem_dst, memwb_dst;
  logic             exmem_regwrite, memwb_regwrite;
  logic             bj_ex, halt_ex, stop, restart;

  logic [1:0]       fwd_a, fwd_b;
  logic             pc_en, if_id_en, pipe_en;
  logic             if_id_flush, id_ex_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, bj_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_dst, ex_memread,
           exmem_dst, memwb_dst, exmem_regwrite, memwb_regwrite,
           bj_ex, halt_ex, stop, restart,
    input  fwd_a, fwd_b, pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush,
           state, cycle_cnt, stall_cnt, bj_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_dst, ex_memread,
           exmem_dst, memwb_dst, exmem_regwrite, memwb_regwrite,
           bj_ex, halt_ex, stop, restart,
    output fwd_a, fwd_b, pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush,
           state, cycle_cnt, stall_cnt, bj_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: forwarding, load-use stall, branch flush and
// RUN/DRAIN/HALTED sequencing. Define PIPE_CTRL_PERF_EN to build the counters.
module pipe_ctrl #(
  parameter int REG_W        = 5,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input logic          clk,
  input logic          rst_n,
  pipe_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_e;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_e         state_q, state_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic           load_use;
  logic           cyc_evt, stall_evt, bj_evt;
  logic           pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush;

  // EX/MEM wins over MEM/WB; register 0 is never forwarded
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
    if (bus.exmem_regwrite && (bus.exmem_dst != '0) && (bus.exmem_dst == src))
      return 2'b01;
    else if (bus.memwb_regwrite && (bus.memwb_dst != '0) && (bus.memwb_dst == src))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign bus.fwd_a = fwd_sel(bus.ex_rs);
  assign bus.fwd_b = fwd_sel(bus.ex_rt);

  assign load_use = bus.ex_memread && (bus.ex_dst != '0) &&
                    ((bus.id_uses_rs && (bus.ex_dst == bus.id_rs)) ||
                     (bus.id_uses_rt && (bus.ex_dst == bus.id_rt)));

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    pipe_en     = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    cyc_evt     = 1'b0;
    stall_evt   = 1'b0;
    bj_evt      = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.stop) begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          pipe_en  = 1'b0;
        end else begin
          cyc_evt = 1'b1;
          // a taken branch squashes the stalled instruction anyway
          if (bus.bj_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            bj_evt      = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_evt   = 1'b1;
          end
          if (bus.halt_ex) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        cyc_evt     = 1'b1;
        if (drain_q == DRAIN_LAST) begin
          state_d = HALTED;
          drain_d = '0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      HALTED: begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
        pipe_en  = 1'b0;
        if (bus.restart) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        drain_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.pipe_en     = pipe_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.state       = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bj_cnt_q, bj_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    cycle_cnt_d = cyc_evt   ? sat_inc(cycle_cnt_q) : cycle_cnt_q;
    stall_cnt_d = stall_evt ? sat_inc(stall_cnt_q) : stall_cnt_q;
    bj_cnt_d    = bj_evt    ? sat_inc(bj_cnt_q)    : bj_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      bj_cnt_q    <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      bj_cnt_q    <= bj_cnt_d;
    end
  end

  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.bj_cnt    = bj_cnt_q;
`else
  logic unused_evt;
  assign unused_evt    = ^{cyc_evt, stall_evt, bj_evt};
  assign bus.cycle_cnt = '0;
  assign bus.stall_cnt = '0;
  assign bus.bj_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: forwarding, load-use, branch, stop, halt/drain,
// restart and asynchronous reset during DRAIN.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   exp_cyc = 0;

  pipe_ctrl_if #(.REG_W(5), .CNT_W(32)) bus ();

  pipe_ctrl #(.REG_W(5), .CNT_W(32), .DRAIN_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ev(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit counted);
    @(posedge clk);
    if (counted) exp_cyc++;
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.ex_rs = '0; bus.ex_rt = '0; bus.ex_dst = '0; bus.ex_memread = 1'b0;
    bus.exmem_dst = '0; bus.memwb_dst = '0;
    bus.exmem_regwrite = 1'b0; bus.memwb_regwrite = 1'b0;
    bus.bj_ex = 1'b0; bus.halt_ex = 1'b0; bus.stop = 1'b0; bus.restart = 1'b0;
  endtask

  task automatic chk_ctrl(input string tag, input logic pc, input logic ifid,
                          input logic pipe, input logic fl_if, input logic fl_ex);
    chk({tag, "_pc_en"},       32'(bus.pc_en),       32'(pc));
    chk({tag, "_if_id_en"},    32'(bus.if_id_en),    32'(ifid));
    chk({tag, "_pipe_en"},     32'(bus.pipe_en),     32'(pipe));
    chk({tag, "_if_id_flush"}, 32'(bus.if_id_flush), 32'(fl_if));
    chk({tag, "_id_ex_flush"}, 32'(bus.id_ex_flush), 32'(fl_ex));
  endtask

  initial begin
    clear_inputs();

    // reset state
    #3;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk_ctrl("rst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_fwd_a", 32'(bus.fwd_a), 32'd0);
    chk("rst_fwd_b", 32'(bus.fwd_b), 32'd0);
    chk("rst_cycle", bus.cycle_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1);
    chk("cyc_after_1", bus.cycle_cnt, ev(exp_cyc));

    // forwarding
    bus.exmem_dst = 5'd5; bus.memwb_dst = 5'd5; bus.ex_rs = 5'd5; bus.ex_rt = 5'd5;
    bus.exmem_regwrite = 1'b1; bus.memwb_regwrite = 1'b1;
    #1;
    chk("fwd_a_exmem", 32'(bus.fwd_a), 32'd1);
    chk("fwd_b_exmem", 32'(bus.fwd_b), 32'd1);
    bus.exmem_regwrite = 1'b0;
    #1;
    chk("fwd_a_memwb", 32'(bus.fwd_a), 32'd2);
    chk("fwd_b_memwb", 32'(bus.fwd_b), 32'd2);
    bus.ex_rs = 5'd0;
    #1;
    chk("fwd_a_r0", 32'(bus.fwd_a), 32'd0);
    chk("fwd_b_still", 32'(bus.fwd_b), 32'd2);
    bus.memwb_dst = 5'd0;
    #1;
    chk("fwd_b_dst0", 32'(bus.fwd_b), 32'd0);
    clear_inputs();
    tick(1'b1);

    // load-use via rt
    bus.ex_memread = 1'b1; bus.ex_dst = 5'd8; bus.id_rt = 5'd8; bus.id_uses_rt = 1'b1;
    #1;
    chk_ctrl("lu", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("lu_stall_before", bus.stall_cnt, 32'd0);
    tick(1'b1);
    clear_inputs();
    #1;
    chk_ctrl("lu_after", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu_stall_cnt", bus.stall_cnt, ev(1));

    // no hazard when the ID instruction does not read the register, or for r0
    bus.ex_memread = 1'b1; bus.ex_dst = 5'd8; bus.id_rs = 5'd8; bus.id_uses_rs = 1'b0;
    #1;
    chk("lu_unused_pc_en", 32'(bus.pc_en), 32'd1);
    bus.ex_dst = 5'd0; bus.id_rs = 5'd0; bus.id_uses_rs = 1'b1;
    #1;
    chk("lu_r0_pc_en", 32'(bus.pc_en), 32'd1);
    clear_inputs();
    tick(1'b1);

    // branch + load-use in the same cycle
    bus.bj_ex = 1'b1;
    bus.ex_memread = 1'b1; bus.ex_dst = 5'd9; bus.id_rs = 5'd9; bus.id_uses_rs = 1'b1;
    #1;
    chk_ctrl("bj", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(1'b1);
    clear_inputs();
    #1;
    chk("bj_cnt", bus.bj_cnt, ev(1));
    chk("bj_stall_cnt", bus.stall_cnt, ev(1));
    chk("bj_cycle", bus.cycle_cnt, ev(exp_cyc));

    // stop for 4 cycles, with branch and halt requests that must be ignored
    bus.stop = 1'b1; bus.bj_ex = 1'b1; bus.halt_ex = 1'b1;
    bus.exmem_regwrite = 1'b1; bus.exmem_dst = 5'd3; bus.ex_rs = 5'd3;
    #1;
    chk_ctrl("stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stop_fwd_a", 32'(bus.fwd_a), 32'd1);
    tick(1'b0); tick(1'b0); tick(1'b0); tick(1'b0);
    chk("stop_state", 32'(bus.state), 32'd0);
    chk("stop_cycle", bus.cycle_cnt, ev(exp_cyc));
    chk("stop_bj_cnt", bus.bj_cnt, ev(1));
    clear_inputs();
    tick(1'b1);

    // halt with concurrent branch, then DRAIN for 3 cycles
    bus.halt_ex = 1'b1; bus.bj_ex = 1'b1;
    #1;
    chk_ctrl("halt_bj", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(1'b1);
    clear_inputs();
    bus.stop = 1'b1; bus.restart = 1'b1; bus.bj_ex = 1'b1;
    #1;
    chk("drain1_state", 32'(bus.state), 32'd1);
    chk_ctrl("drain", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("drain_bj_cnt", bus.bj_cnt, ev(2));
    tick(1'b1);
    clear_inputs();
    chk("drain2_state", 32'(bus.state), 32'd1);
    tick(1'b1);
    chk("drain3_state", 32'(bus.state), 32'd1);
    tick(1'b1);
    chk("halted_state", 32'(bus.state), 32'd2);
    chk_ctrl("halted", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("halted_cycle", bus.cycle_cnt, ev(exp_cyc));
    tick(1'b0); tick(1'b0);
    chk("halted_hold", 32'(bus.state), 32'd2);
    chk("halted_cycle_frozen", bus.cycle_cnt, ev(exp_cyc));
    bus.restart = 1'b1;
    tick(1'b0);
    bus.restart = 1'b0;
    chk("restart_state", 32'(bus.state), 32'd0);
    chk_ctrl("restart", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1);
    chk("run_cycle", bus.cycle_cnt, ev(exp_cyc));

    // reset in the middle of DRAIN
    bus.halt_ex = 1'b1;
    tick(1'b1);
    bus.halt_ex = 1'b0;
    chk("rd_drain1", 32'(bus.state), 32'd1);
    tick(1'b1);
    chk("rd_drain2", 32'(bus.state), 32'd1);
    chk("rd_cycle_pre", bus.cycle_cnt, ev(exp_cyc));
    #2;
    rst_n = 1'b0;
    exp_cyc = 0;
    #1;
    chk("rd_state", 32'(bus.state), 32'd0);
    chk("rd_cycle", bus.cycle_cnt, 32'd0);
    chk("rd_stall", bus.stall_cnt, 32'd0);
    chk("rd_bj", bus.bj_cnt, 32'd0);
    chk_ctrl("rd", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1);
    chk("rd_run_state", 32'(bus.state), 32'd0);
    chk("rd_run_cycle", bus.cycle_cnt, ev(exp_cyc));
    tick(1'b1);
    chk("rd_run_state2", 32'(bus.state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
